bimodal_pred_table: RTL and testbench

//   Parametrised successor to the single 2-bit branch FSM: a table of 2**IDX_W saturating

---
 rtl/bimodal_pred_pkg.sv | 37 +++
 rtl/bimodal_pred_table_sat_counter.sv | 30 +++
 rtl/bimodal_pred_table.sv | 100 ++++++++++
 tb/tb_bimodal_pred_table.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bimodal_pred_pkg.sv
// Shared encodings and helpers for the bimodal branch predictor table.
// Index extraction and saturating counter step are width-generic via int arguments.
package bimodal_pred_pkg;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_CNT_W = 2;

  // Two-bit counter states: strong/weak not-taken, weak/strong taken.
  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt2_e;

  localparam logic [1:0] CNT2_SNT = CNT_SNT;
  localparam logic [1:0] CNT2_WNT = CNT_WNT;
  localparam logic [1:0] CNT2_WT  = CNT_WT;
  localparam logic [1:0] CNT2_ST  = CNT_ST;

  // Word-aligned PCs: the two low bits never carry branch identity.
  function automatic logic [31:0] pc_index(input logic [63:0] pc, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic up,
                                           input int cnt_w);
    logic [31:0] max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    if (up) return (cnt == max_v) ? cnt : cnt + 32'd1;
    else    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bimodal_pred_table_sat_counter.sv
// One saturating counter entry of the predictor table; steps up/down when en is set.
module sat_counter
  import bimodal_pred_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INIT_CNT = 2 ** (CNT_W - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = CNT_W'(sat_step(32'(cnt_q), dir, CNT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= CNT_W'(INIT_CNT);
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bimodal_pred_table.sv
// Bimodal branch predictor: 2**IDX_W saturating counters, 1-cycle registered lookup, train port.
// Define GSHARE_EN to XOR the index with a global history register (gshare indexing).
module bimodal_pred_table
  import bimodal_pred_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INIT_CNT = 2 ** (CNT_W - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CNT_W-1:0] pred_cnt,
`ifdef GSHARE_EN
  output logic [IDX_W-1:0] pred_ghr,
  input  logic [IDX_W-1:0] upd_ghr,
`endif
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [CNT_W-1:0] cnt_arr [DEPTH];
  logic [CNT_W-1:0] rd_cnt;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [CNT_W-1:0] pred_cnt_q;

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;
  logic [IDX_W-1:0] pred_ghr_q;
  logic [IDX_W:0]   ghr_shift;

  // Lookup hashes with the current GHR; update uses the snapshot that travelled with the branch.
  assign lk_idx    = IDX_W'(pc_index(64'(req_pc), IDX_W)) ^ ghr_q;
  assign up_idx    = IDX_W'(pc_index(64'(upd_pc), IDX_W)) ^ upd_ghr;
  assign ghr_shift = {ghr_q, upd_taken};
  assign ghr_d     = ghr_shift[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q      <= '0;
      pred_ghr_q <= '0;
    end else begin
      if (req_valid) pred_ghr_q <= ghr_q;
      if (upd_valid) ghr_q      <= ghr_d;
    end
  end

  assign pred_ghr = pred_ghr_q;
`else
  assign lk_idx = IDX_W'(pc_index(64'(req_pc), IDX_W));
  assign up_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    sat_counter #(
      .CNT_W    (CNT_W),
      .INIT_CNT (INIT_CNT)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (upd_valid && (up_idx == IDX_W'(i))),
      .dir (upd_taken),
      .cnt (cnt_arr[i])
    );
  end

  // Reads the pre-update counter: a same-cycle update to this entry is not bypassed.
  assign rd_cnt = cnt_arr[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_cnt_q   <= '0;
    end else begin
      pred_valid_q <= req_valid;
      if (req_valid) begin
        pred_cnt_q   <= rd_cnt;
        pred_taken_q <= rd_cnt[CNT_W-1];
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_cnt   = pred_cnt_q;

endmodule

// File: tb/tb_bimodal_pred_table.sv
// Directed bench for bimodal_pred_table (IDX_W=4, CNT_W=2); GSHARE_EN adds history checks.
module tb_bimodal_pred_table;

  localparam int PC_W  = 32;
  localparam int IDX_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [PC_W-1:0]  req_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [CNT_W-1:0] pred_cnt;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
`ifdef GSHARE_EN
  logic [IDX_W-1:0] pred_ghr;
  logic [IDX_W-1:0] upd_ghr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bimodal_pred_table #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_cnt   (pred_cnt),
`ifdef GSHARE_EN
    .pred_ghr   (pred_ghr),
    .upd_ghr    (upd_ghr),
`endif
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic train(input logic [PC_W-1:0] pc, input logic t);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = t;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic [1:0] cnt);
    chk({tag, "_vld"}, 32'(pred_valid), 32'd1);
    chk({tag, "_cnt"}, 32'(pred_cnt), 32'(cnt));
    chk({tag, "_tkn"}, 32'(pred_taken), 32'(cnt[1]));
  endtask

  initial begin
    logic [1:0] nt_seq [3];
    nt_seq = '{2'd1, 2'd0, 2'd0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_pc    = '0;
    upd_valid = 1'b0;
    upd_pc    = '0;
    upd_taken = 1'b0;
`ifdef GSHARE_EN
    upd_ghr   = '0;
`endif
    step();
    step();
    chk("rst_vld", 32'(pred_valid), 32'd0);
    chk("rst_cnt", 32'(pred_cnt), 32'd0);
    chk("rst_tkn", 32'(pred_taken), 32'd0);
    rst = 1'b0;

`ifndef GSHARE_EN
    // Fresh table reads weakly taken.
    lookup(32'h0);
    expect_pred("t1", 2'd2);
    step();
    chk("t1_idle_vld", 32'(pred_valid), 32'd0);
    chk("t1_hold_cnt", 32'(pred_cnt), 32'd2);

    // Not-taken training saturates at zero.
    for (int i = 0; i < 3; i++) begin
      train(32'h4, 1'b0);
      lookup(32'h4);
      expect_pred($sformatf("t2_nt%0d", i), nt_seq[i]);
    end
    lookup(32'h8);
    expect_pred("t2_other", 2'd2);
    lookup(32'h7);
    expect_pred("t2_lowbits", 2'd0);

    // Taken training saturates at three.
    for (int i = 0; i < 4; i++) train(32'h10, 1'b1);
    lookup(32'h10);
    expect_pred("t3_sat", 2'd3);
    train(32'h10, 1'b0);
    lookup(32'h10);
    expect_pred("t3_dec", 2'd2);

    // Same-cycle lookup and update to one entry returns the old value.
    train(32'h4, 1'b1);
    train(32'h4, 1'b1);
    req_valid = 1'b1; req_pc = 32'h4;
    upd_valid = 1'b1; upd_pc = 32'h4; upd_taken = 1'b0;
    step();
    req_valid = 1'b0; upd_valid = 1'b0;
    expect_pred("t4_same", 2'd2);
    lookup(32'h4);
    expect_pred("t4_after", 2'd1);

    // 0x44 aliases 0x4 with a 4-bit index.
    lookup(32'h44);
    expect_pred("t5_alias_rd", 2'd1);
    train(32'h44, 1'b0);
    lookup(32'h4);
    expect_pred("t5_alias_wr", 2'd0);
    req_valid = 1'b1; req_pc = 32'h10;
    upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1;
    step();
    req_valid = 1'b0; upd_valid = 1'b0;
    expect_pred("t5_indep_rd", 2'd2);
    lookup(32'h8);
    expect_pred("t5_indep_wr", 2'd3);

    // Reset wins over a concurrent request and update.
    rst = 1'b1;
    req_valid = 1'b1; req_pc = 32'h8;
    upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b0; upd_valid = 1'b0;
    chk("t6_drop_vld", 32'(pred_valid), 32'd0);
    chk("t6_drop_cnt", 32'(pred_cnt), 32'd0);
    lookup(32'h4);
    expect_pred("t6_e1", 2'd2);
    lookup(32'h8);
    expect_pred("t6_e2", 2'd2);
    lookup(32'h10);
    expect_pred("t6_e4", 2'd2);
`else
    // History T,T,NT from zero yields 4'b0110; entry 0 is the trained slot.
    train(32'h0, 1'b1);
    train(32'h0, 1'b1);
    train(32'h0, 1'b0);
    lookup(32'h4);
    expect_pred("g_lk7", 2'd2);
    chk("g_ghr6", 32'(pred_ghr), 32'h6);
    lookup(32'h0);
    expect_pred("g_lk6", 2'd2);
    upd_ghr = 4'h6;
    train(32'h4, 1'b0);
    upd_ghr = 4'h0;
    // GHR is now 4'b1100; pc 0x2C (idx 11) hashes to entry 7.
    lookup(32'h2C);
    expect_pred("g_e7", 2'd1);
    chk("g_ghrc", 32'(pred_ghr), 32'hC);
    lookup(32'h30);
    expect_pred("g_e0", 2'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
